// File: rtl/s7_pkg.sv
// s7_pkg: shared definitions for the 7-segment capture path.
//   - SEG_0 .. SEG_9, SEG_BLANK : segment patterns (bit0 = a .. bit6 = g, 1 = lit)
//   - BCD_BLANK                 : BCD code reported for a blank digit
//   - dwell_state_t             : dwell FSM encoding (IDLE / SETTLE / HELD)
//   - one_hot32()               : true when exactly one bit of the vector is set
package s7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } dwell_state_t;

  // Narrower vectors are zero-extended by the caller; a zero vector is not one-hot.
  function automatic logic one_hot32(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/s7_seg2bcd.sv
// s7_seg2bcd: combinational 7-segment pattern to BCD decoder.
//   segments : input  7-bit pattern (bit0 = a .. bit6 = g)
//   valid    : output 1 when the pattern is a digit 0-9 or blank
//   bcd      : output decoded value (blank -> 4'hF, 4'h0 when invalid)
module s7_seg2bcd
  import s7_pkg::*;
(
  input  logic [6:0] segments,
  output logic       valid,
  output logic [3:0] bcd
);

  // Pattern lookup; anything outside the table is flagged invalid.
  always_comb begin
    valid = 1'b1;
    bcd   = 4'h0;
    case (segments)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default: begin
        valid = 1'b0;
        bcd   = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/s7_segment_capture.sv
// s7_segment_capture: reconstructs the BCD digits shown on a multiplexed
// 7-segment bus. A (select, segments) pair must stay unchanged for
// STABLE_CYCLES samples before it is evaluated once; a frame is published
// once every digit has been captured.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_segments       : segment pattern (bit0 = a .. bit6 = g)
//   i_segments_sel   : one-hot digit select, bit k = digit k
//   o_bcd_data       : last complete frame, nibble k = digit k
//   o_valid          : frame is newer than TIMEOUT_CYCLES
//   o_frame_stb      : one-cycle pulse when o_bcd_data updates
//   o_err            : one-cycle pulse on invalid pattern or multi-hot select
// Optional: define S7_SEGMENT_CAPTURE_SYNC_EN to add 2-flop input
// synchronizers (all latencies grow by 2 cycles).
module s7_segment_capture
  import s7_pkg::*;
#(
  parameter int DISPLAYS_NUM   = 6,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [6:0]                i_segments,
  input  logic [DISPLAYS_NUM-1:0]   i_segments_sel,
  output logic [4*DISPLAYS_NUM-1:0] o_bcd_data,
  output logic                      o_valid,
  output logic                      o_frame_stb,
  output logic                      o_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]        CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]        STABLE_LAST = CNT_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]         TO_ZERO     = TO_W'(0);
  localparam logic [TO_W-1:0]         TO_ONE      = TO_W'(1);
  localparam logic [TO_W-1:0]         TO_LAST     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [DISPLAYS_NUM-1:0] SEL_ZERO    = {DISPLAYS_NUM{1'b0}};
  localparam logic [DISPLAYS_NUM-1:0] MASK_FULL   = {DISPLAYS_NUM{1'b1}};

  logic [6:0]              seg_s;
  logic [DISPLAYS_NUM-1:0] sel_s;

`ifdef S7_SEGMENT_CAPTURE_SYNC_EN
  logic [6:0]              seg_meta_r, seg_sync_r;
  logic [DISPLAYS_NUM-1:0] sel_meta_r, sel_sync_r;

  // Two-flop synchronizers for an asynchronous display source.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_meta_r <= 7'h00;
      seg_sync_r <= 7'h00;
      sel_meta_r <= SEL_ZERO;
      sel_sync_r <= SEL_ZERO;
    end else begin
      seg_meta_r <= i_segments;
      seg_sync_r <= seg_meta_r;
      sel_meta_r <= i_segments_sel;
      sel_sync_r <= sel_meta_r;
    end
  end

  assign seg_s = seg_sync_r;
  assign sel_s = sel_sync_r;
`else
  assign seg_s = i_segments;
  assign sel_s = i_segments_sel;
`endif

  dwell_state_t            state_r, state_nx;
  logic [CNT_W-1:0]        cnt_r, cnt_nx;
  logic [DISPLAYS_NUM-1:0] lat_sel_r, lat_sel_nx;
  logic [6:0]              lat_seg_r, lat_seg_nx;
  logic                    eval_s;
  logic                    pair_same_s;

  assign pair_same_s = (sel_s == lat_sel_r) && (seg_s == lat_seg_r);

  // Dwell FSM next state: a new pair restarts the count at 1, and the
  // cycle the count reaches STABLE_CYCLES is the single evaluation cycle.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    lat_sel_nx = lat_sel_r;
    lat_seg_nx = lat_seg_r;
    eval_s     = 1'b0;
    if (sel_s == SEL_ZERO) begin
      state_nx = IDLE;
      cnt_nx   = CNT_ZERO;
    end else if ((state_r == IDLE) || !pair_same_s) begin
      lat_sel_nx = sel_s;
      lat_seg_nx = seg_s;
      cnt_nx     = CNT_ONE;
      if (CNT_ONE == STABLE_LAST) begin
        eval_s   = 1'b1;
        state_nx = HELD;
      end else begin
        state_nx = SETTLE;
      end
    end else begin
      case (state_r)
        SETTLE: begin
          cnt_nx = cnt_r + CNT_ONE;
          if (cnt_nx == STABLE_LAST) begin
            eval_s   = 1'b1;
            state_nx = HELD;
          end else begin
            state_nx = SETTLE;
          end
        end
        HELD:    state_nx = HELD;
        default: begin
          state_nx = IDLE;
          cnt_nx   = CNT_ZERO;
        end
      endcase
    end
  end

  // Dwell FSM registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      lat_sel_r <= SEL_ZERO;
      lat_seg_r <= 7'h00;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      lat_sel_r <= lat_sel_nx;
      lat_seg_r <= lat_seg_nx;
    end
  end

  logic       dec_valid_s;
  logic [3:0] dec_bcd_s;
  logic       sel_onehot_s;

  s7_seg2bcd u_seg2bcd (
    .segments (seg_s),
    .valid    (dec_valid_s),
    .bcd      (dec_bcd_s)
  );

  assign sel_onehot_s = one_hot32(32'(sel_s));

  logic [DISPLAYS_NUM-1:0][3:0] shadow_r, shadow_nx;
  logic [DISPLAYS_NUM-1:0][3:0] bcd_r, bcd_nx;
  logic [DISPLAYS_NUM-1:0]      mask_r, mask_nx;
  logic [TO_W-1:0]              to_cnt_r, to_cnt_nx;
  logic                         valid_r, valid_nx;
  logic                         stb_r, stb_nx;
  logic                         err_r, err_nx;
  logic                         frame_done_s;

  assign frame_done_s = (mask_r == MASK_FULL);

  // Capture, frame publication and timeout. Clears happen first so a
  // capture in the same cycle lands in the fresh mask.
  always_comb begin
    shadow_nx = shadow_r;
    bcd_nx    = bcd_r;
    mask_nx   = mask_r;
    to_cnt_nx = to_cnt_r;
    valid_nx  = valid_r;
    stb_nx    = 1'b0;
    err_nx    = 1'b0;
    if (frame_done_s) begin
      bcd_nx    = shadow_r;
      valid_nx  = 1'b1;
      stb_nx    = 1'b1;
      to_cnt_nx = TO_ZERO;
      mask_nx   = SEL_ZERO;
    end else if (to_cnt_r != TO_LAST) begin
      to_cnt_nx = to_cnt_r + TO_ONE;
      if (to_cnt_nx == TO_LAST) begin
        valid_nx = 1'b0;
        mask_nx  = SEL_ZERO;
      end else begin
        valid_nx = valid_r;
      end
    end else begin
      to_cnt_nx = to_cnt_r;
    end
    if (eval_s) begin
      if (sel_onehot_s && dec_valid_s) begin
        mask_nx = mask_nx | sel_s;
        for (int k = 0; k < DISPLAYS_NUM; k++) begin
          shadow_nx[k] = sel_s[k] ? dec_bcd_s : shadow_r[k];
        end
      end else begin
        err_nx = 1'b1;
      end
    end else begin
      err_nx = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_r <= '{default: 4'h0};
      bcd_r    <= '{default: 4'h0};
      mask_r   <= SEL_ZERO;
      to_cnt_r <= TO_ZERO;
      valid_r  <= 1'b0;
      stb_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      shadow_r <= shadow_nx;
      bcd_r    <= bcd_nx;
      mask_r   <= mask_nx;
      to_cnt_r <= to_cnt_nx;
      valid_r  <= valid_nx;
      stb_r    <= stb_nx;
      err_r    <= err_nx;
    end
  end

  assign o_bcd_data  = bcd_r;
  assign o_valid     = valid_r;
  assign o_frame_stb = stb_r;
  assign o_err       = err_r;

endmodule
